// File: rtl/hazard_scoreboard.sv
// Forwarding / load-use hazard unit: tracks the destinations of the last DEPTH issued
// instructions and resolves a bypass select per decode operand. HAZARD_STATS_EN adds stall_count.

module hazard_operand #(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int SW         = 2
) (
    input  logic [AW-1:0]             addr,
    input  logic                      used,
    input  logic [DEPTH-1:0]          entV,
    input  logic [DEPTH-1:0]          entWe,
    input  logic [DEPTH-1:0]          entLd,
    input  logic [DEPTH-1:0][AW-1:0]  entRd,
    output logic [SW-1:0]             sel,
    output logic                      stl
);
    // Scan oldest to youngest so the youngest hit overwrites and wins.
    always_comb begin
        sel = '0;
        stl = 1'b0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (used && addr != '0 && entV[k] && entWe[k] && entRd[k] == addr) begin
                sel = SW'(k + 1);
                stl = entLd[k] && (k < LOAD_READY);
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    localparam int SW        = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_we,
    input  logic                 issue_load,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_used,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]          stall_count
`endif
);
    logic [DEPTH-1:0]         vldPipe;
    logic [DEPTH-1:0]         wePipe;
    logic [DEPTH-1:0]         ldPipe;
    logic [DEPTH-1:0][AW-1:0] rdPipe;
    logic [NSRC-1:0]          opStall;

    for (genvar j = 0; j < NSRC; j++) begin : gOp
        hazard_operand #(.AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SW(SW)) uOp (
            .addr  (src_addr[j*AW +: AW]),
            .used  (src_used[j]),
            .entV  (vldPipe),
            .entWe (wePipe),
            .entLd (ldPipe),
            .entRd (rdPipe),
            .sel   (fwd_sel[j*SW +: SW]),
            .stl   (opStall[j])
        );
    end

    assign stall = issue_valid && !flush && (|opStall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vldPipe <= '0;
            wePipe  <= '0;
            ldPipe  <= '0;
            rdPipe  <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                vldPipe[k] <= vldPipe[k-1];
                wePipe[k]  <= wePipe[k-1];
                ldPipe[k]  <= ldPipe[k-1];
                rdPipe[k]  <= rdPipe[k-1];
            end
            vldPipe[0] <= issue_valid && !stall && !flush;
            wePipe[0]  <= issue_we;
            ldPipe[0]  <= issue_load;
            rdPipe[0]  <= issue_rd;
            // Flush also kills the instruction currently in EX as it moves on.
            if (flush)
                vldPipe[1] <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif
endmodule
